axi_wr_queue: RTL and testbench
===============================

// Module: axi_wr_queue
// PURPOSE
//  Multi-entry AXI3 write master between the d-cache and the AXI crossbar. Queues up to DEPTH
//  writes: burst victim lines or single uncached stores. Issues AW and W independently and
//  keeps entries until their B response arrives. Replaces the blanket read stall with a
//  per-address read-after-write hazard check.
// PARAMETERS
//  BYTES_PER_LINE  16  cache line bytes; power of 2, 8..64; burst len = BYTES_PER_LINE/4 beats
//  DEPTH            4  queue entries; power of 2, 2..8
//  AXI_ID           1  constant value driven on awid/wid
// PORTS
//  clk            in   1          clock, all state on rising edge
//  resetn         in   1          asynchronous, active-low reset
//  wr_req         in   1          enqueue request; accepted when wr_req & wr_rdy
//  wr_rdy         out  1          queue has a free entry
//  burst          in   1          1: full-line INCR burst; 0: single beat
//  data           in   8*BPL      line data; word 0 in bits [31:0]; single beat uses [31:0]
//  addr           in   32         byte address; line-aligned when burst=1
//  size           in   2          single-beat awsize
//  strb           in   4          single-beat wstrb
//  rd_check_addr  in   32         address of a pending d-cache/uncached read
//  rd_hazard      out  1          some live entry overlaps rd_check_addr's line
//  wr_idle        out  1          queue empty and nothing outstanding
//  bresp_err      out  1          sticky: some B response had bresp != OKAY
//  aw*/w*/b*      AXI3 write channels, same widths as the existing AXI masters
//                 (awlen 8, wid 4, bid 4)
// BEHAVIOUR
//  - Reset (resetn=0, async): pointers and count go to 0, bresp_err goes to 0.
//    Outputs: awvalid=wvalid=0, wr_rdy=1, wr_idle=1, rd_hazard=0, bready=1.
//    Reset during a transaction abandons it; the interconnect is reset with us.
//  - Four pointers mod DEPTH, each with an extra wrap bit: tail (enq), aw_p, w_p, head (B retire).
//    Always head <= w_p <= aw_p <= tail in queue order.
//  - wr_rdy = (count < DEPTH). Registered, so no same-cycle bypass from a retire.
//  - Enqueue and retire in the same cycle leave count unchanged.
//  - Enqueue latches data/addr/burst/size/strb into entry[tail].
//    Awvalid may rise at the earliest the next cycle (no comb path from wr_req to AXI).
//  - AW: awvalid = (aw_p != tail). Fields come from entry[aw_p].
//    Burst: awsize=2, awburst=INCR, awlen=BPL/4-1.
//    Single: awsize={0,size}, awburst=FIXED, awlen=0.
//    aw_p advances on awvalid & awready. Fields stay stable while awvalid & ~awready.
//  - W: wvalid = (w_p != aw_p), so W never precedes its own AW.
//    wdata = entry[w_p] word beat; wstrb = 4'hF for burst, strb for single.
//    Beat counter increments on handshake. wlast = last beat (burst) or 1 (single).
//    On wlast handshake: w_p advances and the beat counter clears to 0.
//  - B: bready=1 always. bvalid retires entry[head]; head advances.
//    bresp != 0 sets bresp_err; bid is ignored.
//    bvalid while head == w_p is illegal: assertion fires, head holds.
//  - rd_hazard: combinational OR over live entries (head..tail-1).
//    Compare addr[31:log2(BPL)] with rd_check_addr[31:log2(BPL)].
//    Compare is line-granular even for single entries (conservative).
//    An entry being enqueued this cycle is not included; the read requester must sample the next cycle.
//  - wr_idle = (count == 0). Reported only after B of the last entry.
//  - AW of entry n+1 may run ahead of W of entry n, up to DEPTH entries in flight.
// STRUCTURE
//  - Shared include axi_defs.vh: BURST_FIXED=2'b00, BURST_INCR=2'b01, RESP_OKAY=2'b00, AXI size encodings.
//  - One sub-module: axi_wr_entry_ram.
//    DEPTH x (8*BPL+32+1+2+4) register array.
//    1 write port, 2 async read ports (AW fields, W data); addr/valid tap for hazard compare.
//    Pointer/count logic and channel control stay in the top module.
//  - The existing mux_1h selects burst vs single AW/W fields.
// TESTING
//  1. Single store: addr=0x1FC0_0004, strb=4'b0011, size=1; awready/wready=1; B on cycle 3.
//     -> awlen=0, awburst=FIXED, wlast=1, wstrb=0011; wr_idle returns to 1 after B.
//  2. Burst: BPL=16, addr=0x0000_1230, data words 0..3 = A0..A3; wready toggles 1,0,1,...
//     -> 4 beats in order A0..A3, wlast only on A3, awlen=3.
//  3. Fill: 4 enqueues with awready=0 -> wr_rdy=0 after the 4th.
//     A 5th wr_req is not accepted. Release awready -> 4 AWs back-to-back, then W in order.
//  4. Hazard: entry addr=0x8000_0040 live -> rd_hazard=1 for rd_check_addr=0x8000_004C.
//     rd_hazard=0 for 0x8000_0050. It drops the cycle after that entry's B.
//  5. Simultaneous: enqueue in the same cycle as a B retire at count=DEPTH-1 -> count unchanged, no lost entry.
//     bresp=2'b10 on one B -> bresp_err=1 and it holds.
//  6. Reset: assert resetn=0 mid-burst (beat 2) -> awvalid=wvalid=0 immediately.
//     After release, wr_idle=1 and the next enqueue starts at beat 0.

Source files
------------

// File: rtl/axi_wr_queue_pkg.sv
// Shared AXI encodings and small helpers for the write queue.
package axi_wr_queue_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    localparam logic [2:0] SIZE_1B = 3'd0;
    localparam logic [2:0] SIZE_2B = 3'd1;
    localparam logic [2:0] SIZE_4B = 3'd2;

    // Two-way one-hot select: sel[1] picks in_1, sel[0] picks in_0.
    function automatic logic [31:0] mux_1h_32(input logic [1:0]  sel,
                                              input logic [31:0] in_0,
                                              input logic [31:0] in_1);
        return ({32{sel[0]}} & in_0) | ({32{sel[1]}} & in_1);
    endfunction

endpackage

// File: rtl/axi_wr_queue_if.sv
// AXI3 write-address, write-data and write-response channels.
// Handshake: a transfer happens on a rising clock edge where valid and ready are
// both 1; a source holds valid and its payload stable until that edge, and valid
// never depends combinationally on ready.
interface axi_wr_queue_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic [3:0]  wid;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        output wvalid, wdata, wstrb, wlast, wid,
        output bready,
        input  awready, wready, bvalid, bresp, bid
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        input  wvalid, wdata, wstrb, wlast, wid,
        input  bready,
        output awready, wready, bvalid, bresp, bid
    );

endinterface

// File: rtl/axi_wr_entry_ram.sv
// Entry storage for the write queue: one write port, an AW-side read port, a
// W-side read port and a tap of every entry's line address for hazard compare.
module axi_wr_entry_ram
    import axi_wr_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 128,
    parameter int LW    = 4
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(DEPTH)-1:0]      wr_idx,
    input  logic [DW-1:0]                 wr_data,
    input  logic [31:0]                   wr_addr,
    input  logic                          wr_burst,
    input  logic [1:0]                    wr_size,
    input  logic [3:0]                    wr_strb,
    input  logic [$clog2(DEPTH)-1:0]      aw_idx,
    output logic [31:0]                   aw_addr,
    output logic                          aw_burst,
    output logic [1:0]                    aw_size,
    input  logic [$clog2(DEPTH)-1:0]      w_idx,
    output logic [DW-1:0]                 w_data,
    output logic                          w_burst,
    output logic [3:0]                    w_strb,
    output logic [DEPTH-1:0][31-LW:0]     line_tap
);

    logic [DEPTH-1:0][DW-1:0] data_q,  data_d;
    logic [DEPTH-1:0][31:0]   addr_q,  addr_d;
    logic [DEPTH-1:0]         burst_q, burst_d;
    logic [DEPTH-1:0][1:0]    size_q,  size_d;
    logic [DEPTH-1:0][3:0]    strb_q,  strb_d;

    // Write the addressed entry on an accepted enqueue, hold everything else.
    always_comb begin
        data_d  = data_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        size_d  = size_q;
        strb_d  = strb_q;
        if (we) begin
            data_d[wr_idx]  = wr_data;
            addr_d[wr_idx]  = wr_addr;
            burst_d[wr_idx] = wr_burst;
            size_d[wr_idx]  = wr_size;
            strb_d[wr_idx]  = wr_strb;
        end
    end

    // Storage carries no reset; entries are only read once they are live.
    always_ff @(posedge clk) begin
        data_q  <= data_d;
        addr_q  <= addr_d;
        burst_q <= burst_d;
        size_q  <= size_d;
        strb_q  <= strb_d;
    end

    assign aw_addr  = addr_q[aw_idx];
    assign aw_burst = burst_q[aw_idx];
    assign aw_size  = size_q[aw_idx];
    assign w_data   = data_q[w_idx];
    assign w_burst  = burst_q[w_idx];
    assign w_strb   = strb_q[w_idx];

    // Line-address tap of every entry; liveness is decided by the pointer owner.
    always_comb begin
        line_tap = '0;
        for (int i = 0; i < DEPTH; i++) begin
            line_tap[i] = addr_q[i][31:LW];
        end
    end

endmodule

// File: rtl/axi_wr_queue.sv
// Multi-entry AXI3 write master. Entries are enqueued at tail, issued on AW at
// aw_p, streamed on W at w_p and retired at head when their B arrives.
module axi_wr_queue
    import axi_wr_queue_pkg::*;
#(
    parameter int         BYTES_PER_LINE = 16,
    parameter int         DEPTH          = 4,
    parameter logic [3:0] AXI_ID         = 4'd1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          wr_req,
    output logic                          wr_rdy,
    input  logic                          burst,
    input  logic [8*BYTES_PER_LINE-1:0]   data,
    input  logic [31:0]                   addr,
    input  logic [1:0]                    size,
    input  logic [3:0]                    strb,
    input  logic [31:0]                   rd_check_addr,
    output logic                          rd_hazard,
    output logic                          wr_idle,
    output logic                          bresp_err,
    axi_wr_queue_if.master                m
);

    localparam int PW    = $clog2(DEPTH);
    localparam int BEATS = BYTES_PER_LINE / 4;
    localparam int BW    = $clog2(BEATS);
    localparam int LW    = $clog2(BYTES_PER_LINE);
    localparam int DW    = 8 * BYTES_PER_LINE;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]   tail_q, tail_d;
    logic [PW:0]   aw_p_q, aw_p_d;
    logic [PW:0]   w_p_q,  w_p_d;
    logic [PW:0]   head_q, head_d;
    logic [PW:0]   count_q, count_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          wr_rdy_q, wr_rdy_d;
    logic          bresp_err_q, bresp_err_d;

    logic          enq, aw_hs, w_hs, ret;
    logic          awvalid_c, wvalid_c, wlast_c;

    logic [31:0]               aw_addr;
    logic                      aw_burst;
    logic [1:0]                aw_size;
    logic [DW-1:0]             w_data;
    logic                      w_burst;
    logic [3:0]                w_strb;
    logic [DEPTH-1:0][31-LW:0] line_tap;

    axi_wr_entry_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .LW    (LW)
    ) u_ram (
        .clk      (clk),
        .we       (enq),
        .wr_idx   (tail_q[PW-1:0]),
        .wr_data  (data),
        .wr_addr  (addr),
        .wr_burst (burst),
        .wr_size  (size),
        .wr_strb  (strb),
        .aw_idx   (aw_p_q[PW-1:0]),
        .aw_addr  (aw_addr),
        .aw_burst (aw_burst),
        .aw_size  (aw_size),
        .w_idx    (w_p_q[PW-1:0]),
        .w_data   (w_data),
        .w_burst  (w_burst),
        .w_strb   (w_strb),
        .line_tap (line_tap)
    );

    // Channel valids come from registered pointers only, so wr_req never reaches AXI combinationally.
    always_comb begin
        awvalid_c = (aw_p_q != tail_q);
        wvalid_c  = (w_p_q != aw_p_q);
        wlast_c   = w_burst ? (beat_q == BW'(BEATS - 1)) : 1'b1;
        enq       = wr_req & wr_rdy_q;
        aw_hs     = awvalid_c & m.awready;
        w_hs      = wvalid_c & m.wready;
        ret       = m.bvalid & (head_q != w_p_q);
    end

    // Next-state for pointers, occupancy, beat counter and the sticky error.
    always_comb begin
        tail_d      = tail_q + {{PW{1'b0}}, enq};
        aw_p_d      = aw_p_q + {{PW{1'b0}}, aw_hs};
        w_p_d       = w_p_q + {{PW{1'b0}}, (w_hs & wlast_c)};
        head_d      = head_q + {{PW{1'b0}}, ret};
        beat_d      = beat_q;
        count_d     = count_q;
        bresp_err_d = bresp_err_q;
        if (w_hs) begin
            beat_d = wlast_c ? '0 : beat_q + BW'(1);
        end
        case ({enq, ret})
            2'b10:   count_d = count_q + {{PW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{PW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        wr_rdy_d = (count_d < (PW+1)'(DEPTH));
        if (ret && (m.bresp != RESP_OKAY)) begin
            bresp_err_d = 1'b1;
        end
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tail_q      <= '0;
            aw_p_q      <= '0;
            w_p_q       <= '0;
            head_q      <= '0;
            count_q     <= '0;
            beat_q      <= '0;
            wr_rdy_q    <= 1'b1;
            bresp_err_q <= 1'b0;
        end else begin
            tail_q      <= tail_d;
            aw_p_q      <= aw_p_d;
            w_p_q       <= w_p_d;
            head_q      <= head_d;
            count_q     <= count_d;
            beat_q      <= beat_d;
            wr_rdy_q    <= wr_rdy_d;
            bresp_err_q <= bresp_err_d;
        end
    end

    // Line-granular overlap against every live entry (head .. tail-1).
    logic [PW-1:0] slot;
    always_comb begin
        rd_hazard = 1'b0;
        slot      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = PW'(i) - head_q[PW-1:0];
            if (({1'b0, slot} < count_q) && (line_tap[i] == rd_check_addr[31:LW])) begin
                rd_hazard = 1'b1;
            end
        end
    end

    assign wr_rdy    = wr_rdy_q;
    assign wr_idle   = (count_q == '0);
    assign bresp_err = bresp_err_q;

    assign m.awvalid = awvalid_c;
    assign m.awaddr  = aw_addr;
    assign m.awlen   = aw_burst ? 8'(BEATS - 1) : 8'd0;
    assign m.awsize  = aw_burst ? SIZE_4B : {1'b0, aw_size};
    assign m.awburst = aw_burst ? BURST_INCR : BURST_FIXED;
    assign m.awid    = AXI_ID;

    assign m.wvalid  = wvalid_c;
    assign m.wdata   = mux_1h_32({w_burst, ~w_burst}, w_data[31:0], w_data[{beat_q, 5'd0} +: 32]);
    assign m.wstrb   = w_burst ? 4'hF : w_strb;
    assign m.wlast   = wlast_c;
    assign m.wid     = AXI_ID;

    assign m.bready  = 1'b1;

    // bid carries no information for a single-ID master; low read-address bits are below line granularity.
    logic unused_ok;
    assign unused_ok = ^{m.bid, rd_check_addr[LW-1:0]};

    // A response with no entry whose data has been sent is a protocol error upstream.
    bvalid_with_no_sent_entry: assert property (
        @(posedge clk) disable iff (!resetn) !(m.bvalid && (head_q == w_p_q))
    );

endmodule

// File: tb/tb_axi_wr_queue.sv
// Randomised and directed bench for axi_wr_queue against a transaction-level model.
module tb_axi_wr_queue;

    localparam int BPL   = 16;
    localparam int DEPTH = 4;
    localparam int BEATS = BPL / 4;
    localparam int LW    = 4;

    logic             clk;
    logic             resetn;
    logic             wr_req;
    logic             wr_rdy;
    logic             burst;
    logic [8*BPL-1:0] data;
    logic [31:0]      addr;
    logic [1:0]       size;
    logic [3:0]       strb;
    logic [31:0]      rd_check_addr;
    logic             rd_hazard;
    logic             wr_idle;
    logic             bresp_err;

    axi_wr_queue_if axi ();

    axi_wr_queue #(
        .BYTES_PER_LINE (BPL),
        .DEPTH          (DEPTH),
        .AXI_ID         (4'd1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .wr_req        (wr_req),
        .wr_rdy        (wr_rdy),
        .burst         (burst),
        .data          (data),
        .addr          (addr),
        .size          (size),
        .strb          (strb),
        .rd_check_addr (rd_check_addr),
        .rd_hazard     (rd_hazard),
        .wr_idle       (wr_idle),
        .bresp_err     (bresp_err),
        .m             (axi)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: expected channel traffic and live line addresses
    logic [48:0]    exp_aw_q[$];
    logic [40:0]    exp_w_q[$];
    logic [31-LW:0] live_q[$];
    int n_enq, n_aw, n_wdone, n_b, w_beats;
    logic model_err;
    int total, bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_aw_q.delete();
        exp_w_q.delete();
        live_q.delete();
        n_enq = 0; n_aw = 0; n_wdone = 0; n_b = 0;
        model_err = 1'b0;
    endtask

    task automatic model_enq();
        live_q.push_back(addr[31:LW]);
        n_enq++;
        if (burst) begin
            exp_aw_q.push_back({addr, 8'(BEATS - 1), 3'd2, 2'b01, 4'd1});
            for (int i = 0; i < BEATS; i++)
                exp_w_q.push_back({data[i*32 +: 32], 4'hF, (i == BEATS - 1), 4'd1});
        end else begin
            exp_aw_q.push_back({addr, 8'd0, {1'b0, size}, 2'b00, 4'd1});
            exp_w_q.push_back({data[31:0], strb, 1'b1, 4'd1});
        end
    endtask

    // Called at a falling edge with inputs already set: checks outputs, advances the model, returns at the next falling edge.
    task automatic cycle();
        int   cnt;
        logic haz, exp_awv, exp_wv, last;
        #1;
        cnt = live_q.size();
        check("wr_rdy", wr_rdy, cnt < DEPTH);
        check("wr_idle", wr_idle, cnt == 0);
        haz = 1'b0;
        foreach (live_q[i]) if (live_q[i] == rd_check_addr[31:LW]) haz = 1'b1;
        check("rd_hazard", rd_hazard, haz);
        check("bresp_err", bresp_err, model_err);
        exp_awv = (n_aw < n_enq);
        exp_wv  = (n_wdone < n_aw);
        check("awvalid", axi.awvalid, exp_awv);
        check("wvalid", axi.wvalid, exp_wv);
        check("bready", axi.bready, 1'b1);
        if (exp_awv && axi.awvalid)
            check("aw_fields", {axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid}, exp_aw_q[0]);
        if (exp_wv && axi.wvalid)
            check("w_beat", {axi.wdata, axi.wstrb, axi.wlast, axi.wid}, exp_w_q[0]);
        if (exp_wv && axi.wready) begin
            last = exp_w_q[0][4];
            void'(exp_w_q.pop_front());
            w_beats++;
            if (last) n_wdone++;
        end
        if (exp_awv && axi.awready) begin
            void'(exp_aw_q.pop_front());
            n_aw++;
        end
        if (axi.bvalid) begin
            void'(live_q.pop_front());
            n_b++;
            if (axi.bresp != 2'b00) model_err = 1'b1;
        end
        if (wr_req && cnt < DEPTH) model_enq();
        @(posedge clk);
        @(negedge clk);
    endtask

    // driver tasks
    task automatic set_req(input logic b, input logic [31:0] a, input logic [1:0] sz, input logic [3:0] st);
        wr_req = 1'b1;
        burst  = b;
        addr   = a;
        size   = sz;
        strb   = st;
        data   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain(input int n);
        wr_req = 1'b0;
        for (int k = 0; k < n; k++) begin
            axi.bvalid = (n_wdone > n_b);
            axi.bresp  = 2'b00;
            cycle();
        end
        axi.bvalid = 1'b0;
    endtask

    int start;

    initial begin
        total = 0; bad = 0; w_beats = 0;
        model_reset();
        resetn = 1'b0; wr_req = 1'b0; burst = 1'b0; data = '0; addr = '0;
        size = 2'd0; strb = 4'h0; rd_check_addr = 32'h0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.bresp = 2'b00; axi.bid = 4'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();
        resetn = 1'b1;
        cycle();

        // single uncached store
        axi.awready = 1'b1; axi.wready = 1'b1;
        rd_check_addr = 32'h1FC0_0000;
        set_req(1'b0, 32'h1FC0_0004, 2'd1, 4'b0011);
        cycle();
        drain(6);

        // full-line burst with wready toggling
        set_req(1'b1, 32'h0000_1230, 2'd0, 4'h0);
        data = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        cycle();
        wr_req = 1'b0;
        for (int k = 0; k < 14; k++) begin
            axi.wready = (k % 2 == 0);
            axi.bvalid = (n_wdone > n_b);
            cycle();
        end
        axi.wready = 1'b1;
        drain(4);

        // fill the queue with AW held off, then release
        axi.awready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b0, 32'h8000_0100 + 32'(i * 16), 2'd2, 4'hF);
            cycle();
        end
        wr_req = 1'b0;
        axi.awready = 1'b1;
        drain(20);

        // read-after-write hazard
        axi.awready = 1'b0;
        rd_check_addr = 32'h8000_004C;
        set_req(1'b1, 32'h8000_0040, 2'd0, 4'h0);
        cycle();
        wr_req = 1'b0;
        cycle();
        cycle();
        rd_check_addr = 32'h8000_0050;
        cycle();
        rd_check_addr = 32'h8000_004C;
        axi.awready = 1'b1;
        drain(15);

        // enqueue alongside a retire at DEPTH-1 entries, plus an error response
        for (int i = 0; i < DEPTH - 1; i++) begin
            set_req(1'b0, 32'h8000_0200 + 32'(i * 4), 2'd2, 4'hF);
            cycle();
        end
        wr_req = 1'b0;
        for (int k = 0; k < 20 && n_wdone < DEPTH - 1; k++) cycle();
        if (n_wdone < DEPTH - 1) check("t5_timeout", 1'b0, 1'b1);
        set_req(1'b0, 32'h8000_0300, 2'd0, 4'h1);
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b10;
        cycle();
        wr_req = 1'b0;
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        check("t5_rdy_after_swap", wr_rdy, 1'b1);
        drain(20);

        // reset in the middle of a burst
        start = w_beats;
        set_req(1'b1, 32'h8000_0400, 2'd0, 4'h0);
        rd_check_addr = 32'h8000_0404;
        cycle();
        wr_req = 1'b0;
        for (int k = 0; k < 20 && (w_beats - start) < 2; k++) cycle();
        if ((w_beats - start) < 2) check("t6_timeout", 1'b0, 1'b1);
        resetn = 1'b0;
        #1;
        check("rst_awvalid", axi.awvalid, 1'b0);
        check("rst_wvalid", axi.wvalid, 1'b0);
        check("rst_wr_idle", wr_idle, 1'b1);
        check("rst_wr_rdy", wr_rdy, 1'b1);
        check("rst_rd_hazard", rd_hazard, 1'b0);
        check("rst_bresp_err", bresp_err, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        cycle();
        set_req(1'b1, 32'h8000_0500, 2'd0, 4'h0);
        cycle();
        drain(12);

        // randomised traffic
        for (int k = 0; k < 1500; k++) begin
            wr_req = ($urandom_range(0, 2) != 0);
            burst  = $urandom_range(0, 1);
            data   = {$urandom, $urandom, $urandom, $urandom};
            addr   = 32'h8000_0000 + (32'($urandom_range(0, 7)) << LW);
            if (!burst) addr = addr + 32'(4 * $urandom_range(0, 3));
            size   = 2'($urandom_range(0, 2));
            strb   = 4'($urandom_range(0, 15));
            rd_check_addr = 32'h8000_0000 + 32'($urandom_range(0, 8 * BPL - 1));
            axi.awready = ($urandom_range(0, 3) != 0);
            axi.wready  = ($urandom_range(0, 3) != 0);
            axi.bvalid  = (n_wdone > n_b) && ($urandom_range(0, 2) != 0);
            axi.bresp   = ($urandom_range(0, 39) == 0) ? 2'b10 : 2'b00;
            cycle();
        end

        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        drain(60);
        check("final_idle", wr_idle, 1'b1);
        check("final_model_empty", 64'(live_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
